// File: rtl/jedro_1_ifu.sv
// ---------------------------------------------------------------------------
// jedro_1_ifu -- instruction fetch unit for the jedro_1 core.
//
// Sits between the synchronous instruction ROM (one cycle read latency) and
// the decoder. It issues word-aligned fetch addresses and buffers each
// returned word together with its PC in a small prefetch FIFO. The FIFO head
// is presented to the decoder over a valid/ready handshake. A redirect pulse
// flushes the FIFO and restarts fetch at the new target.
//
// Ports
//   clk_i              core clock, all state on posedge
//   rstn_i             asynchronous active-low reset
//   instr_mem_addr_o   fetch byte address (ROM uses bits [ADDR_WIDTH-1:2])
//   instr_mem_rdata_i  ROM word, valid one cycle after the address
//   instr_o            FIFO head instruction
//   pc_o               FIFO head PC
//   instr_valid_o      FIFO head is valid
//   decoder_ready_i    decoder accepts the head this cycle
//   jmp_instr_i        single-cycle redirect request
//   jmp_addr_i         redirect target (bits [1:0] ignored)
// ---------------------------------------------------------------------------
module jedro_1_ifu #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      BOOT_ADDR  = '0,
  parameter int unsigned                DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic [ADDR_WIDTH-1:0] instr_mem_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_mem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  input  logic                  decoder_ready_i,
  input  logic                  jmp_instr_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  fetch_pc_reg;
  logic [ADDR_WIDTH-1:0]  issued_pc_reg;
  logic                   inflight_reg;
  logic                   squash_reg;
  logic [CW-1:0]          count_reg;
  logic [PW-1:0]          wr_ptr_reg;
  logic [PW-1:0]          rd_ptr_reg;
  logic [DATA_WIDTH-1:0]  instr_last_reg;
  logic [ADDR_WIDTH-1:0]  pc_last_reg;

  logic [DATA_WIDTH-1:0]  instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

  logic                   pop;
  logic                   push;
  logic                   issue;
  logic [CW-1:0]          occupancy;
  logic                   jmp_addr_unused;

  // Low target bits are forced to zero, so they are intentionally dropped.
  assign jmp_addr_unused = ^jmp_addr_i[1:0];

  // ---------------------------------------------------------------------
  // Control FSM: one idle cycle after reset release, then run forever.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == IDLE) state_next = RUN;
  end

  // ---------------------------------------------------------------------
  // Handshake and issue decisions.
  // A redirect cycle never pops (the shown entry is wrong-path) and never
  // issues (the old fetch_pc is wrong-path too).
  // ---------------------------------------------------------------------
  assign pop  = instr_valid_o & decoder_ready_i & ~jmp_instr_i;
  assign push = inflight_reg & ~squash_reg & ~jmp_instr_i;

  // Slots that will be committed after this cycle: stored entries plus the
  // response in flight, minus the entry leaving now.
  assign occupancy = count_reg + CW'(inflight_reg) - CW'(pop);
  assign issue     = (state_reg == RUN) & ~jmp_instr_i & (occupancy < CW'(DEPTH));

  assign instr_mem_addr_o = fetch_pc_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_pc_reg  <= BOOT_ADDR;
      issued_pc_reg <= BOOT_ADDR;
      inflight_reg  <= 1'b0;
      squash_reg    <= 1'b0;
    end else begin
      inflight_reg <= issue;
      // A response caught by a redirect is discarded; the guard only lives
      // for the cycle right after the redirect.
      squash_reg   <= jmp_instr_i & inflight_reg;
      if (jmp_instr_i) begin
        fetch_pc_reg <= {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (issue) begin
        fetch_pc_reg  <= fetch_pc_reg + ADDR_WIDTH'(4);
        issued_pc_reg <= fetch_pc_reg;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Prefetch FIFO storage, one register pair per entry.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] instr_q;
      logic [ADDR_WIDTH-1:0] pc_q;

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          instr_q <= '0;
          pc_q    <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          instr_q <= instr_mem_rdata_i;
          pc_q    <= issued_pc_reg;
        end
      end

      assign instr_mem[gi] = instr_q;
      assign pc_mem[gi]    = pc_q;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      instr_last_reg <= '0;
      pc_last_reg    <= '0;
    end else begin
      if (pop) begin
        instr_last_reg <= instr_mem[rd_ptr_reg];
        pc_last_reg    <= pc_mem[rd_ptr_reg];
      end
      if (jmp_instr_i) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  // When empty the outputs hold the last consumed entry; there is no
  // path from the ROM data straight to the decoder.
  assign instr_valid_o = (count_reg != '0);
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_reg] : instr_last_reg;
  assign pc_o          = instr_valid_o ? pc_mem[rd_ptr_reg]    : pc_last_reg;

endmodule

// File: tb/tb_jedro_1_ifu.sv
module tb_jedro_1_ifu;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rstn;
  logic [31:0] instr_mem_addr;
  logic [31:0] instr_mem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        decoder_ready;
  logic        jmp_instr;
  logic [31:0] jmp_addr;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  jedro_1_ifu #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BOOT_ADDR (32'h0),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .instr_mem_addr_o (instr_mem_addr),
    .instr_mem_rdata_i(instr_mem_rdata),
    .instr_o          (instr),
    .pc_o             (pc),
    .instr_valid_o    (instr_valid),
    .decoder_ready_i  (decoder_ready),
    .jmp_instr_i      (jmp_instr),
    .jmp_addr_i       (jmp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: 0x00000013, 0x00100f93, 0x00200f93, ...
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (idx == 0) return 32'h0000_0013;
    return 32'h0010_0f93 + ((idx - 1) << 20);
  endfunction

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) instr_mem_rdata <= rom_word(instr_mem_addr);

  // Scoreboard consumer: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (rstn && instr_valid && decoder_ready && !jmp_instr) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL accept_unexpected: accepted pc=%h instr=%h, required no acceptance", pc, instr);
      end else begin
        exp_pc = exp_q.pop_front();
        if (pc !== exp_pc || instr !== rom_word(exp_pc))
          $display("FAIL accept_order: pc=%h instr=%h, required pc=%h instr=%h",
                   pc, instr, exp_pc, rom_word(exp_pc));
        else
          pass_cnt++;
      end
      $display("accept pc=%h instr=%h", pc, instr);
    end
  end

  // A push must never land in a full FIFO.
  always @(negedge clk) begin
    if (rstn && dut.push) begin
      total_cnt++;
      if (dut.count_reg >= DEPTH)
        $display("FAIL push_full: count=%0d on push, required < %0d", dut.count_reg, DEPTH);
      else
        pass_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic rdy);
    @(posedge clk); #1;
    rstn          = 1'b0;
    jmp_instr     = 1'b0;
    jmp_addr      = '0;
    decoder_ready = rdy;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid: valid=%b, required 0", instr_valid);
    else pass_cnt++;
    total_cnt++;
    if (instr !== 32'h0 || pc !== 32'h0) $display("FAIL reset_head: instr=%h pc=%h, required 0/0", instr, pc);
    else pass_cnt++;
    total_cnt++;
    if (instr_mem_addr !== 32'h0) $display("FAIL reset_addr: addr=%h, required 0", instr_mem_addr);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hc);
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b1 || pc !== 32'h0)
      $display("FAIL stream_first: valid=%b pc=%h, required 1/00000000", instr_valid, pc);
    else pass_cnt++;
    repeat (4) @(posedge clk); #1;
    decoder_ready = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL stream_nobubble: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    $display("test_stream done");
  endtask

  task automatic test_stall;
    do_reset(1'b0);
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b1 || pc !== 32'h0)
      $display("FAIL stall_first: valid=%b pc=%h, required 1/00000000", instr_valid, pc);
    else pass_cnt++;
    repeat (5) @(posedge clk); #1;
    total_cnt++;
    if (instr_mem_addr !== 32'h8) $display("FAIL stall_addr: addr=%h, required 00000008", instr_mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (instr_valid !== 1'b1 || pc !== 32'h0)
      $display("FAIL stall_head: valid=%b pc=%h, required 1/00000000", instr_valid, pc);
    else pass_cnt++;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    decoder_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    decoder_ready = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL stall_drain: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    $display("test_stall done");
  endtask

  task automatic test_redirect;
    do_reset(1'b1);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b1) $display("FAIL redir_pre: valid=%b, required 1", instr_valid);
    else pass_cnt++;
    jmp_instr = 1'b1; jmp_addr = 32'h40;
    @(posedge clk); #1;
    jmp_instr = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL redir_flush: valid=%b, required 0", instr_valid);
    else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b1 || pc !== 32'h40)
      $display("FAIL redir_target: valid=%b pc=%h, required 1/00000040", instr_valid, pc);
    else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    decoder_ready = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL redir_drain: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    $display("test_redirect done");
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    repeat (3) @(posedge clk); #1;
    jmp_instr = 1'b1; jmp_addr = 32'h43;
    @(posedge clk); #1;
    jmp_instr = 1'b0;
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b1 || pc !== 32'h40)
      $display("FAIL align_target: valid=%b pc=%h, required 1/00000040", instr_valid, pc);
    else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    decoder_ready = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL align_drain: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    @(posedge clk); #1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    jmp_instr = 1'b1; jmp_addr = 32'h80;
    @(posedge clk); #1;
    jmp_addr = 32'h100;
    @(posedge clk); #1;
    jmp_instr = 1'b0; decoder_ready = 1'b1;
    total_cnt++;
    if (instr_mem_addr !== 32'h100) $display("FAIL b2b_issue: addr=%h, required 00000100", instr_mem_addr);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL b2b_gap: valid=%b, required 0", instr_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b1 || pc !== 32'h100)
      $display("FAIL b2b_target: valid=%b pc=%h, required 1/00000100", instr_valid, pc);
    else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    decoder_ready = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL b2b_drain: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset;
    do_reset(1'b1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    repeat (3) @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL async_valid: valid=%b, required 0", instr_valid);
    else pass_cnt++;
    total_cnt++;
    if (instr_mem_addr !== 32'h0 || pc !== 32'h0)
      $display("FAIL async_state: addr=%h pc=%h, required 0/0", instr_mem_addr, pc);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL async_pre: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if (instr_valid !== 1'b1 || pc !== 32'h0)
      $display("FAIL async_restart: valid=%b pc=%h, required 1/00000000", instr_valid, pc);
    else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    decoder_ready = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL async_drain: pending=%0d, required 0", exp_q.size());
    else pass_cnt++;
    $display("test_async_reset done");
  endtask

  initial begin
    rstn          = 1'b0;
    decoder_ready = 1'b0;
    jmp_instr     = 1'b0;
    jmp_addr      = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
